// File: rtl/complex_bus_slave_mem_if.sv
// complex_bus link: master drives address/data/byte_enable/valid,
// slave answers with ready/error.
interface complex_bus;
  logic [31:0] address;
  logic [63:0] data;
  logic [7:0]  byte_enable;
  logic        valid;
  logic        ready;
  logic        error;

  modport master (
    output address, data, byte_enable, valid,
    input  ready, error
  );

  modport slave (
    input  address, data, byte_enable, valid,
    output ready, error
  );
endinterface

// File: rtl/complex_bus_slave_mem.sv
// Write-only complex_bus memory slave with wait states and debug port.
// Optional sticky error flag: define COMPLEX_BUS_SLAVE_STICKY_ERR_EN.
module complex_bus_slave_mem #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  complex_bus.slave                bus,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [63:0]              rd_data,
  output logic [31:0]              wr_count,
`ifdef COMPLEX_BUS_SLAVE_STICKY_ERR_EN
  output logic [15:0]              err_count,
  input  logic                     err_clr,
  output logic                     err_sticky
`else
  output logic [15:0]              err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [63:0]     data_q, data_d;
  logic [7:0]      be_q, be_d;
  logic            derr_q, derr_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;
  logic [63:0]     rd_data_q;
  logic [31:0]     wr_count_q;
  logic [15:0]     err_count_q;
  logic [63:0]     mem_q [DEPTH];

  logic [31:0]     off;
  logic            dec_err;
  logic            hs;

  assign off     = bus.address - BASE_ADDR;
  assign dec_err = (bus.address[2:0] != 3'b000)
                || (bus.address < BASE_ADDR)
                || ((off >> 3) >= DEPTH);
  assign hs      = (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    be_d    = be_q;
    derr_d  = derr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          idx_d   = off[AW+2:3];
          data_d  = bus.data;
          be_d    = bus.byte_enable;
          derr_d  = dec_err;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // master dropping valid mid-wait abandons the transfer
        if (!bus.valid) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RESP);
    error_d = (state_d == S_RESP) && derr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      be_q        <= '0;
      derr_q      <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      rd_data_q   <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      be_q      <= be_d;
      derr_q    <= derr_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rd_data_q <= mem_q[rd_addr];
      if (hs && !derr_q) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
      if (hs && derr_q && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (hs && !derr_q) begin
      for (int b = 0; b < 8; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

`ifdef COMPLEX_BUS_SLAVE_STICKY_ERR_EN
  logic sticky_q;

  // a new error outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (hs && derr_q) begin
      sticky_q <= 1'b1;
    end else if (err_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign err_sticky = sticky_q;
`endif

  assign bus.ready = ready_q;
  assign bus.error = error_q;
  assign rd_data   = rd_data_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;

endmodule
